fwd_scoreboard: RTL

//  Parametrised forwarding/hazard unit for the RISC-V pipeline. It replaces the fixed s1-vs-s3 compare with a DEPTH-entry

---
 rtl/fwd_scoreboard_pkg.sv | 38 +++
 rtl/fwd_scoreboard_match.sv | 28 ++
 rtl/fwd_scoreboard.sv | 107 ++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared opcodes, scoreboard entry layout and decode helpers for the forwarding scoreboard.
package fwd_scoreboard_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  function automatic logic opc_writes_rd(input logic [6:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_ITYPE) || (opc == OPC_AUIPC) ||
           (opc == OPC_LUI)   || (opc == OPC_LOAD)  || (opc == OPC_JAL)   ||
           (opc == OPC_JALR)  || (opc == OPC_CSR);
  endfunction

  // CSR immediate forms (func3[2]=1) carry a zimm in the rs1 field, not a register.
  function automatic logic opc_uses_rs1(input logic [6:0] opc, input logic [2:0] func3);
    return (opc == OPC_RTYPE) || (opc == OPC_STORE) || (opc == OPC_BRANCH) ||
           (opc == OPC_ITYPE) || (opc == OPC_LOAD)  || (opc == OPC_JALR)   ||
           ((opc == OPC_CSR) && !func3[2]);
  endfunction

  function automatic logic opc_uses_rs2(input logic [6:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_match.sv
// Priority compare of one source register against every in-flight writer; youngest entry wins.
module fwd_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 1,
  parameter int SELW       = 2
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [4:0]            rs,
  input  logic                  use_rs,
  output logic [SELW-1:0]       sel,
  output logic                  hit_load_early
);

  // Scan oldest to youngest so the last assignment is the smallest matching index.
  always_comb begin
    sel            = '0;
    hit_load_early = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (use_rs && (rs != 5'd0) && entries[k].valid && (entries[k].rd == rs)) begin
        sel            = SELW'(k + 1);
        hit_load_early = entries[k].is_load && (k < LOAD_READY);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Shift-register scoreboard of in-flight writers producing per-source forward selects.
// Define LOAD_STALL_EN to stall decode on a load-use hazard; otherwise stall is tied low.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter  int DEPTH        = 2,
  parameter  int LOAD_READY   = 1,
  parameter  int FLUSH_STAGES = 1,
  localparam int SELW         = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic            s1_valid,
  input  logic [31:0]     instruction_s1,
  input  logic            bp_enable,
  output logic [SELW-1:0] fwd_sel_1,
  output logic [SELW-1:0] fwd_sel_2,
  output logic            stall,
  output logic            label_sel
);

  sb_entry_t [DEPTH-1:0] entry_reg;
  sb_entry_t [DEPTH-1:0] entry_next;

  logic [6:0] opc;
  logic [4:0] rd;
  logic [2:0] func3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       writer;
  logic       use_rs1;
  logic       use_rs2;

  assign opc     = instruction_s1[6:0];
  assign rd      = instruction_s1[11:7];
  assign func3   = instruction_s1[14:12];
  assign rs1     = instruction_s1[19:15];
  assign rs2     = instruction_s1[24:20];
  assign writer  = opc_writes_rd(opc) && (rd != 5'd0);
  assign use_rs1 = s1_valid && opc_uses_rs1(opc, func3);
  assign use_rs2 = s1_valid && opc_uses_rs2(opc);

  assign label_sel = bp_enable && (opc == OPC_BRANCH);

  logic [SELW-1:0] sel_1_raw;
  logic [SELW-1:0] sel_2_raw;
  logic            hit_1_early;
  logic            hit_2_early;

  fwd_match #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .SELW(SELW)) u_match_rs1 (
    .entries        (entry_reg),
    .rs             (rs1),
    .use_rs         (use_rs1),
    .sel            (sel_1_raw),
    .hit_load_early (hit_1_early)
  );

  fwd_match #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .SELW(SELW)) u_match_rs2 (
    .entries        (entry_reg),
    .rs             (rs2),
    .use_rs         (use_rs2),
    .sel            (sel_2_raw),
    .hit_load_early (hit_2_early)
  );

`ifdef LOAD_STALL_EN
  // A source waiting on an unready load must not pick up a stale forward.
  assign stall     = hit_1_early || hit_2_early;
  assign fwd_sel_1 = hit_1_early ? '0 : sel_1_raw;
  assign fwd_sel_2 = hit_2_early ? '0 : sel_2_raw;
`else
  logic unused_hits;
  assign unused_hits = hit_1_early ^ hit_2_early;
  assign stall       = 1'b0;
  assign fwd_sel_1   = sel_1_raw;
  assign fwd_sel_2   = sel_2_raw;
`endif

  // Entry 0 records s1 (bubble on stall); older entries shift; flush kills the young ones.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_next
      sb_entry_t shifted;
      if (gi == 0) begin : g_head
        assign shifted.valid   = s1_valid && writer && !stall;
        assign shifted.rd      = rd;
        assign shifted.is_load = (opc == OPC_LOAD);
      end else begin : g_tail
        assign shifted = entry_reg[gi-1];
      end
      assign entry_next[gi].valid   = shifted.valid && !(flush && (gi < FLUSH_STAGES));
      assign entry_next[gi].rd      = shifted.rd;
      assign entry_next[gi].is_load = shifted.is_load;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_reg <= '0;
    end else if (en) begin
      entry_reg <= entry_next;
    end
  end

endmodule
